// File: rtl/seq_divider_8by4_if.sv
// Handshake and operand/result bundle for the sequential 8-by-4 divider.
// The master side issues requests; the slave side is the divider itself.
interface seq_divider_8by4_if #(
   parameter int DIVIDEND_W = 8,
   parameter int DIVISOR_W  = 4
);
   logic                  start;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic                  busy;
   logic                  done;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider_8by4.sv
// Iterative radix-2 restoring divider. It resolves one quotient bit per clock.
// Results and the divide-by-zero flag are held until the next completion or reset.
module seq_divider_8by4 #(
   parameter int DIVIDEND_W = 8,
   parameter int DIVISOR_W  = 4
) (
   input logic                clk,
   input logic                rst,
   seq_divider_8by4_if.slave  bus
);
   localparam int                CNT_W = $clog2(DIVIDEND_W + 1);
   localparam logic [CNT_W-1:0]  ITERATIONS = CNT_W'(DIVIDEND_W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state;
   state_t                state_next;
   logic [DIVIDEND_W-1:0] d_reg;
   logic [DIVIDEND_W-1:0] d_next;
   logic [DIVISOR_W-1:0]  r_reg;
   logic [DIVISOR_W-1:0]  r_next;
   logic [DIVISOR_W:0]    r_shift;
   logic [DIVISOR_W-1:0]  divisor_reg;
   logic [CNT_W-1:0]      count;
   logic                  ge;
   logic                  accept;
   logic                  zero_div;
   logic                  last_step;

   assign accept    = bus.start && ((state == IDLE) || (state == DONE));
   assign zero_div  = (bus.divisor == '0);
   assign last_step = (state == RUN) && (count == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start) state_next = zero_div ? DONE : RUN;
         end
         RUN: begin
            if (count == CNT_W'(1)) state_next = DONE;
         end
         DONE: begin
            if (bus.start) state_next = zero_div ? DONE : RUN;
            else           state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == RUN);
      bus.done = (state == DONE);
   end

   // After a successful subtraction the true difference is below 16, so the
   // 4-bit modular subtract is exact; the 5th bit only matters for the compare.
   always_comb begin
      r_shift = {r_reg, d_reg[DIVIDEND_W-1]};
      ge      = (r_shift >= {1'b0, divisor_reg});
      r_next  = ge ? (r_shift[DIVISOR_W-1:0] - divisor_reg) : r_shift[DIVISOR_W-1:0];
      d_next  = {d_reg[DIVIDEND_W-2:0], ge};
   end

   // The dividend register doubles as the quotient shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_reg           <= '0;
         r_reg           <= '0;
         divisor_reg     <= '0;
         count           <= '0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.div_by_zero <= 1'b0;
      end else if (accept) begin
         d_reg       <= bus.dividend;
         r_reg       <= '0;
         divisor_reg <= bus.divisor;
         count       <= ITERATIONS;
         if (zero_div) begin
            bus.quotient    <= '1;
            bus.remainder   <= bus.dividend[DIVISOR_W-1:0];
            bus.div_by_zero <= 1'b1;
         end
      end else if (state == RUN) begin
         d_reg <= d_next;
         r_reg <= r_next;
         count <= count - CNT_W'(1);
         if (last_step) begin
            bus.quotient    <= d_next;
            bus.remainder   <= r_next;
            bus.div_by_zero <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_seq_divider_8by4.sv
// Directed self-checking bench for seq_divider_8by4: reset, boundaries, divide-by-zero,
// mid-run reset, ignored/back-to-back starts and an exhaustive invariant sweep.
module tb_seq_divider_8by4;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   seq_divider_8by4_if #(.DIVIDEND_W(8), .DIVISOR_W(4)) bus ();

   seq_divider_8by4 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present a start pulse at the next rising edge; returns just after that edge.
   task automatic applyStimulus(input logic [7:0] dd, input logic [3:0] dv);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = dd;
      bus.divisor  = dv;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Watch cycles after an accepting edge; done_cycle is -1 if done never shows.
   task automatic monitor_done(output int done_cycle, output int busy_cnt, output logic busy_at_done);
      done_cycle   = -1;
      busy_cnt     = 0;
      busy_at_done = 1'bx;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.done === 1'b1) begin
            done_cycle   = i;
            busy_at_done = bus.busy;
            break;
         end
      end
   endtask

   task automatic run_div(input logic [7:0] dd, input logic [3:0] dv,
                          output int done_cycle, output int busy_cnt, output logic busy_at_done);
      applyStimulus(dd, dv);
      monitor_done(done_cycle, busy_cnt, busy_at_done);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_flags: busy/done/dbz=%b required 000", {bus.busy, bus.done, bus.div_by_zero});
      end
      checks++;
      if ({bus.quotient, bus.remainder} !== 12'h000) begin
         errors++;
         $display("[TB] FAIL reset_results: q=%h r=%h required q=00 r=0", bus.quotient, bus.remainder);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int   dc;
      int   bc;
      logic bd;
      run_div(8'd200, 4'd13, dc, bc, bd);
      checks++;
      if (dc !== 9) begin
         errors++;
         $display("[TB] FAIL basic_latency: done at cycle %0d required 9", dc);
      end
      checks++;
      if (bc !== 8 || bd !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_busy: busy cycles %0d busy_at_done %b required 8 and 0", bc, bd);
      end
      checks++;
      if (bus.quotient !== 8'h0F || bus.remainder !== 4'h5 || bus.div_by_zero !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_result: q=%h r=%h dbz=%b required q=0f r=5 dbz=0",
                  bus.quotient, bus.remainder, bus.div_by_zero);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.quotient !== 8'h0F) begin
         errors++;
         $display("[TB] FAIL basic_hold: done=%b q=%h required done=0 q=0f", bus.done, bus.quotient);
      end
   endtask

   task automatic test_boundaries();
      logic [7:0] dd [3] = '{8'd255, 8'd7, 8'd225};
      logic [3:0] dv [3] = '{4'd1, 4'd9, 4'd15};
      logic [7:0] eq [3] = '{8'hFF, 8'h00, 8'h0F};
      logic [3:0] er [3] = '{4'h0, 4'h7, 4'h0};
      int   dc;
      int   bc;
      logic bd;
      for (int i = 0; i < 3; i++) begin
         run_div(dd[i], dv[i], dc, bc, bd);
         checks++;
         if (dc !== 9 || bus.quotient !== eq[i] || bus.remainder !== er[i]) begin
            errors++;
            $display("[TB] FAIL boundary_%0d_%0d: done_cycle=%0d q=%h r=%h required 9 q=%h r=%h",
                     dd[i], dv[i], dc, bus.quotient, bus.remainder, eq[i], er[i]);
         end
      end
   endtask

   task automatic test_div_by_zero();
      int   dc;
      int   bc;
      logic bd;
      run_div(8'hA7, 4'd0, dc, bc, bd);
      checks++;
      if (dc !== 1 || bc !== 0) begin
         errors++;
         $display("[TB] FAIL dbz_timing: done_cycle=%0d busy_cycles=%0d required 1 and 0", dc, bc);
      end
      checks++;
      if (bus.quotient !== 8'hFF || bus.remainder !== 4'h7 || bus.div_by_zero !== 1'b1) begin
         errors++;
         $display("[TB] FAIL dbz_result: q=%h r=%h dbz=%b required q=ff r=7 dbz=1",
                  bus.quotient, bus.remainder, bus.div_by_zero);
      end
      @(negedge clk);
      checks++;
      if (bus.div_by_zero !== 1'b1 || bus.done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dbz_hold: dbz=%b done=%b required dbz=1 done=0", bus.div_by_zero, bus.done);
      end
      run_div(8'd10, 4'd3, dc, bc, bd);
      checks++;
      if (dc !== 9 || bus.quotient !== 8'd3 || bus.remainder !== 4'd1 || bus.div_by_zero !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dbz_clear: done_cycle=%0d q=%h r=%h dbz=%b required 9 q=03 r=1 dbz=0",
                  dc, bus.quotient, bus.remainder, bus.div_by_zero);
      end
   endtask

   task automatic test_reset_mid_run();
      int   dc;
      int   bc;
      logic bd;
      int   stray_done;
      applyStimulus(8'd200, 4'd13);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.quotient !== 8'h00 || bus.remainder !== 4'h0) begin
         errors++;
         $display("[TB] FAIL midreset_state: busy=%b done=%b dbz=%b q=%h r=%h required all zero",
                  bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
      end
      rst = 1'b0;
      stray_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray_done++;
      end
      checks++;
      if (stray_done !== 0) begin
         errors++;
         $display("[TB] FAIL midreset_quiet: %0d cycles with done/busy high required 0", stray_done);
      end
      run_div(8'd100, 4'd7, dc, bc, bd);
      checks++;
      if (dc !== 9 || bus.quotient !== 8'd14 || bus.remainder !== 4'd2) begin
         errors++;
         $display("[TB] FAIL midreset_fresh: done_cycle=%0d q=%h r=%h required 9 q=0e r=2",
                  dc, bus.quotient, bus.remainder);
      end
   endtask

   task automatic test_back_to_back();
      int   dc;
      int   bc;
      logic bd;
      applyStimulus(8'd99, 4'd4);
      repeat (2) @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 8'd50;
      bus.divisor  = 4'd5;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      monitor_done(dc, bc, bd);
      checks++;
      if (dc !== 7 || bus.quotient !== 8'd24 || bus.remainder !== 4'd3) begin
         errors++;
         $display("[TB] FAIL ignore_start: done_cycle=%0d q=%h r=%h required 7 q=18 r=3",
                  dc, bus.quotient, bus.remainder);
      end
      bus.start    = 1'b1;
      bus.dividend = 8'd50;
      bus.divisor  = 4'd5;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      monitor_done(dc, bc, bd);
      checks++;
      if (dc !== 9 || bc !== 8 || bus.quotient !== 8'd10 || bus.remainder !== 4'd0) begin
         errors++;
         $display("[TB] FAIL back_to_back: done_cycle=%0d busy=%0d q=%h r=%h required 9 8 q=0a r=0",
                  dc, bc, bus.quotient, bus.remainder);
      end
   endtask

   task automatic test_exhaustive();
      int   dc;
      int   bc;
      logic bd;
      int   q_exp;
      int   r_exp;
      for (int a = 0; a < 256; a++) begin
         for (int b = 1; b < 16; b++) begin
            run_div(8'(a), 4'(b), dc, bc, bd);
            q_exp = a / b;
            r_exp = a % b;
            checks++;
            if (dc !== 9 || bus.div_by_zero !== 1'b0 ||
                (int'(bus.quotient) * b + int'(bus.remainder)) != a ||
                int'(bus.remainder) >= b || int'(bus.quotient) != q_exp || int'(bus.remainder) != r_exp) begin
               errors++;
               $display("[TB] FAIL exhaustive_%0d_%0d: done_cycle=%0d q=%0d r=%0d dbz=%b required 9 q=%0d r=%0d dbz=0",
                        a, b, dc, bus.quotient, bus.remainder, bus.div_by_zero, q_exp, r_exp);
            end
         end
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      test_reset();
      test_basic();
      test_boundaries();
      test_div_by_zero();
      test_reset_mid_run();
      test_back_to_back();
      test_exhaustive();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
